// File: rtl/fg_dac_write_sequencer.sv
// Function-generator DAC write sequencer: each accepted sample runs SETUP -> WRITE -> HOLD -> SETTLE.
// Latency: sample on bus 1 cycle after acceptance; dac_wr_n_o falls after SETUP_CYCLES more cycles.
// Backpressure: none; one-entry pending buffer, newest overwrites (sticky overflow_o).
// Optional macro FG_DAC_DROP_CNT_EN adds the saturating drop_cnt_o overwrite counter.
module fg_dac_write_sequencer #(
   parameter int SETUP_CYCLES  = 1,
   parameter int WR_LOW_CYCLES = 2,
   parameter int HOLD_CYCLES   = 1,
   parameter int SETTLE_CYCLES = 500,
   parameter int CNT_W         = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] sample_i,
   input  logic       sample_valid_i,
   input  logic       clr_ovf_i,
   output logic [7:0] dac_data_o,
   output logic       dac_wr_n_o,
   output logic       dac_clr_n_o,
   output logic       busy_o,
`ifdef FG_DAC_DROP_CNT_EN
   output logic [7:0] drop_cnt_o,
`endif
   output logic       overflow_o
);

   typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, SETTLE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic             wr_n_q, wr_n_d;
   logic             clr_n_q;
   logic [7:0]       pend_q, pend_d;
   logic             pend_full_q, pend_full_d;
   logic             ovf_q, ovf_d;
   logic             ovf_set;
   logic             phase_last;
`ifdef FG_DAC_DROP_CNT_EN
   logic [7:0]       drop_q, drop_d;
`endif

   // Detect the final cycle of the current timed phase.
   always_comb begin
      phase_last = 1'b0;
      case (state_q)
         SETUP:   phase_last = (cnt_q == CNT_W'(SETUP_CYCLES - 1));
         WRITE:   phase_last = (cnt_q == CNT_W'(WR_LOW_CYCLES - 1));
         HOLD:    phase_last = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
         SETTLE:  phase_last = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
         default: phase_last = 1'b0;
      endcase
   end

   // Next-state logic: phase sequencing, sample hand-over and pending buffer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      wr_n_d      = wr_n_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      ovf_set     = 1'b0;

      if (state_q != IDLE) begin
         cnt_d = phase_last ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (sample_valid_i) begin
               state_d = SETUP;
               data_d  = sample_i;
            end
         end
         SETUP: begin
            if (phase_last) begin
               state_d = WRITE;
               wr_n_d  = 1'b0;
            end
         end
         WRITE: begin
            if (phase_last) begin
               state_d = HOLD;
               wr_n_d  = 1'b1;
            end
         end
         HOLD: begin
            if (phase_last) state_d = SETTLE;
         end
         SETTLE: begin
            if (phase_last) begin
               // Back-to-back restart: the pending sample goes first, a
               // simultaneous new sample takes its place without overflow.
               if (pend_full_q) begin
                  state_d     = SETUP;
                  data_d      = pend_q;
                  pend_full_d = sample_valid_i;
                  if (sample_valid_i) pend_d = sample_i;
               end else if (sample_valid_i) begin
                  state_d = SETUP;
                  data_d  = sample_i;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Capture into pending while busy, except at the hand-over cycle above.
      if ((state_q != IDLE) && !((state_q == SETTLE) && phase_last) && sample_valid_i) begin
         pend_d      = sample_i;
         pend_full_d = 1'b1;
         ovf_set     = pend_full_q;
      end

      ovf_d = ovf_set | (ovf_q & ~clr_ovf_i);

`ifdef FG_DAC_DROP_CNT_EN
      if (clr_ovf_i)                   drop_d = ovf_set ? 8'd1 : 8'd0;
      else if (ovf_set && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      else                             drop_d = drop_q;
`endif
   end

   // State and registered outputs; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         data_q      <= 8'h00;
         wr_n_q      <= 1'b1;
         clr_n_q     <= 1'b0;
         pend_q      <= 8'h00;
         pend_full_q <= 1'b0;
         ovf_q       <= 1'b0;
`ifdef FG_DAC_DROP_CNT_EN
         drop_q      <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         wr_n_q      <= wr_n_d;
         clr_n_q     <= 1'b1;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         ovf_q       <= ovf_d;
`ifdef FG_DAC_DROP_CNT_EN
         drop_q      <= drop_d;
`endif
      end
   end

   assign dac_data_o  = data_q;
   assign dac_wr_n_o  = wr_n_q;
   assign dac_clr_n_o = clr_n_q;
   assign busy_o      = (state_q != IDLE);
   assign overflow_o  = ovf_q;
`ifdef FG_DAC_DROP_CNT_EN
   assign drop_cnt_o  = drop_q;
`endif

endmodule

// File: tb/tb_fg_dac_write_sequencer.sv
// Bench for fg_dac_write_sequencer: per-cycle vector table on a short-timing instance,
// a default-parameter timing sequence, and a drop-counter saturation sequence.
// Written DAC words are checked against a scoreboard queue at each dac_wr_n_o fall.
module tb_fg_dac_write_sequencer;

`ifdef FG_DAC_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   initial forever #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic [7:0] smp_a = 8'h00, smp_b = 8'h00;
   logic       vld_a = 1'b0, vld_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
   logic [7:0] data_a, data_b, drop_a;
   logic       wr_n_a, wr_n_b, clr_n_a, clr_n_b, busy_a, busy_b, ovf_a, ovf_b;
`ifdef FG_DAC_DROP_CNT_EN
   logic [7:0] drop_b;
`endif

   fg_dac_write_sequencer #(
      .SETUP_CYCLES(1), .WR_LOW_CYCLES(2), .HOLD_CYCLES(1), .SETTLE_CYCLES(4), .CNT_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sample_i(smp_a), .sample_valid_i(vld_a), .clr_ovf_i(clr_a),
      .dac_data_o(data_a), .dac_wr_n_o(wr_n_a), .dac_clr_n_o(clr_n_a), .busy_o(busy_a),
`ifdef FG_DAC_DROP_CNT_EN
      .drop_cnt_o(drop_a),
`endif
      .overflow_o(ovf_a)
   );
`ifndef FG_DAC_DROP_CNT_EN
   assign drop_a = 8'h00;
`endif

   fg_dac_write_sequencer dut_dflt (
      .clk(clk), .rst_n(rst_n), .sample_i(smp_b), .sample_valid_i(vld_b), .clr_ovf_i(clr_b),
      .dac_data_o(data_b), .dac_wr_n_o(wr_n_b), .dac_clr_n_o(clr_n_b), .busy_o(busy_b),
`ifdef FG_DAC_DROP_CNT_EN
      .drop_cnt_o(drop_b),
`endif
      .overflow_o(ovf_b)
   );

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      bit          chk;
      bit          rst;
      bit          vld;
      logic [7:0]  smp;
      bit          push;
      bit          clr;
      logic [19:0] exp;   // {wr_n, clr_n, busy, ovf, drop[7:0], data[7:0]}
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb[$];
   bit         sb_en = 1'b1;
   logic       prev_wr_n = 1'b1;
   int         wr_idx = 0;

   task automatic check(input string nm, input int idx, input logic [19:0] act, input logic [19:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
      end
   endtask

   function automatic logic [7:0] dc(input logic [7:0] x);
      return DROP_EN ? x : 8'h00;
   endfunction

   function automatic logic [19:0] ex(input bit wr_n, input bit clr_n, input bit busy, input bit ovf,
                                      input logic [7:0] drop, input logic [7:0] data);
      return {wr_n, clr_n, busy, ovf, drop, data};
   endfunction

   task automatic v(input bit chk, input bit rst, input bit vld, input logic [7:0] smp,
                    input bit push, input bit clr, input logic [19:0] e);
      vec_t t;
      t = '{chk, rst, vld, smp, push, clr, e};
      vecs.push_back(t);
   endtask

   // Reset cycle (outputs not checked), optionally with a valid that must be ignored.
   task automatic rw(input bit vld, input logic [7:0] smp);
      v(1'b0, 1'b1, vld, smp, 1'b0, 1'b0, 20'h0);
   endtask

   // First cycle after reset: reset-state outputs, then drive inputs.
   task automatic r0(input bit vld, input logic [7:0] smp, input bit push);
      v(1'b1, 1'b0, vld, smp, push, 1'b0, ex(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
   endtask

   task automatic r(input bit vld, input logic [7:0] smp, input bit push, input bit clr,
                    input bit wr_n, input bit busy, input bit ovf, input logic [7:0] drop,
                    input logic [7:0] data, input int n);
      for (int k = 0; k < n; k++) v(1'b1, 1'b0, vld, smp, push, clr, ex(wr_n, 1'b1, busy, ovf, drop, data));
   endtask

   // Scoreboard: every falling write strobe must carry the next expected word.
   always @(negedge clk) begin
      if (sb_en && prev_wr_n && !wr_n_a) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write[%0d]: got data %h, want no write", wr_idx, data_a);
         end else begin
            check("write_data", wr_idx, {12'h0, data_a}, {12'h0, sb.pop_front()});
         end
         wr_idx++;
      end
      prev_wr_n <= wr_n_a;
   end

   initial begin
      bit         do_chk;
      logic [9:0] e10;

      // Vectors for the short-timing instance (SETUP=1, WR_LOW=2, HOLD=1, SETTLE=4).
      // Single pending sample, written back-to-back, no overflow.
      rw(1'b1, 8'h99);
      r0(1'b1, 8'h10, 1'b1);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h10, 1);
      r(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h10, 1);
      r(1, 8'h20, 1, 0, 0, 1, 0, 8'h00, 8'h10, 1);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h10, 5);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h20, 1);
      r(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h20, 2);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h20, 5);
      r(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h20, 1);
      // Overwrite of pending: newest wins, overflow sticky until cleared.
      rw(1'b0, 8'h00);
      r0(1'b1, 8'h10, 1'b1);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h10, 1);
      r(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h10, 1);
      r(1, 8'h20, 0, 0, 0, 1, 0, 8'h00, 8'h10, 1);
      r(1, 8'h30, 1, 0, 1, 1, 0, 8'h00, 8'h10, 1);
      r(0, 8'h00, 0, 0, 1, 1, 1, dc(8'd1), 8'h10, 4);
      r(0, 8'h00, 0, 0, 1, 1, 1, dc(8'd1), 8'h30, 1);
      r(0, 8'h00, 0, 0, 0, 1, 1, dc(8'd1), 8'h30, 2);
      r(0, 8'h00, 0, 0, 1, 1, 1, dc(8'd1), 8'h30, 5);
      r(0, 8'h00, 0, 1, 1, 0, 1, dc(8'd1), 8'h30, 1);
      r(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h30, 1);
      // Valid on last SETTLE cycle, with pending full and then with pending empty.
      rw(1'b0, 8'h00);
      r0(1'b1, 8'h11, 1'b1);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h11, 1);
      r(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h11, 1);
      r(1, 8'h44, 1, 0, 0, 1, 0, 8'h00, 8'h11, 1);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h11, 4);
      r(1, 8'h55, 1, 0, 1, 1, 0, 8'h00, 8'h11, 1);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h44, 1);
      r(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h44, 2);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h44, 5);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h55, 1);
      r(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h55, 2);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h55, 4);
      r(1, 8'h77, 1, 0, 1, 1, 0, 8'h00, 8'h55, 1);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h77, 1);
      r(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h77, 2);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h77, 5);
      r(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h77, 1);
      // Reset during the second WRITE cycle discards in-flight and pending samples.
      rw(1'b0, 8'h00);
      r0(1'b1, 8'hC3, 1'b1);
      r(0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'hC3, 1);
      r(1, 8'h3C, 0, 0, 0, 1, 0, 8'h00, 8'hC3, 1);
      v(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, ex(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hC3));
      v(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ex(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
      r(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00, 20);

      // Default-parameter instance: one sample 0xA5 accepted at cycle 0.
      repeat (2) @(negedge clk);
      for (int c = 0; c <= 506; c++) begin
         @(negedge clk);
         do_chk = 1'b1;
         e10    = 10'h0;
         case (c)
            0:        e10 = {1'b1, 1'b0, 8'h00};
            1:        e10 = {1'b1, 1'b1, 8'hA5};
            2, 3:     e10 = {1'b0, 1'b1, 8'hA5};
            4, 504:   e10 = {1'b1, 1'b1, 8'hA5};
            505, 506: e10 = {1'b1, 1'b0, 8'hA5};
            default:  do_chk = 1'b0;
         endcase
         if (do_chk) check("dflt_timing", c, {10'h0, wr_n_b, busy_b, data_b}, {10'h0, e10});
         rst_n = 1'b1;
         vld_b = (c == 0);
         smp_b = 8'hA5;
      end

      // Table run on the short-timing instance.
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         if (vecs[i].chk)
            check("vec", i, {wr_n_a, clr_n_a, busy_a, ovf_a, drop_a, data_a}, vecs[i].exp);
         rst_n = !vecs[i].rst;
         vld_a = vecs[i].vld;
         smp_a = vecs[i].smp;
         clr_a = vecs[i].clr;
         if (vecs[i].push) sb.push_back(vecs[i].smp);
      end
      @(negedge clk);
      check("sb_drained", 0, 20'(sb.size()), 20'd0);

      // Continuous valids: overflow and drop-counter saturation, then clear.
      sb_en = 1'b0;
      rst_n = 1'b0;
      vld_a = 1'b0;
      clr_a = 1'b0;
      for (int c = 0; c <= 405; c++) begin
         @(negedge clk);
         if (c == 400) check("drop_sat", c, {11'h0, ovf_a, drop_a}, {11'h0, 1'b1, dc(8'hFF)});
         if (c == 404) check("clr_vs_set", c, {11'h0, ovf_a, drop_a}, {11'h0, 1'b1, dc(8'h01)});
         if (c == 405) check("clr", c, {11'h0, ovf_a, drop_a}, {11'h0, 1'b0, 8'h00});
         rst_n = 1'b1;
         vld_a = (c <= 403);
         smp_a = 8'(c);
         clr_a = (c == 403) || (c == 404);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
